// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall / bubble / flush control for an in-order
// pipeline with a multi-stage data memory. Data-cache miss outranks load-use,
// which outranks instruction-cache miss, which outranks branch flush.
// Optional build macro HAZARD_PERF_COUNTERS_EN enables the stall-cycle and
// flush performance counters; without it both counter ports are tied to 0.
module pipeline_hazard_controller #(
    parameter int REG_ADD_WIDTH    = 5,
    parameter int D_CACHE_LW_WIDTH = 3,
    parameter int DM_STAGES        = 3,
    parameter int BRANCH_PENALTY   = 2,
    parameter int STALL_TIMEOUT    = 1024,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                                    CLK,
    input  logic                                    RST_N,
    input  logic                                    INSTRUCTION_CACHE_READY,
    input  logic                                    DATA_CACHE_READY,
    input  logic                                    BRANCH_TAKEN_EXECUTION,
    input  logic [REG_ADD_WIDTH-1:0]                RS1_ADDRESS_EXECUTION,
    input  logic [REG_ADD_WIDTH-1:0]                RS2_ADDRESS_EXECUTION,
    input  logic [DM_STAGES*D_CACHE_LW_WIDTH-1:0]   DATA_CACHE_LOAD_DM,
    input  logic [DM_STAGES*REG_ADD_WIDTH-1:0]      RD_ADDRESS_DM,
    output logic                                    STALL_PROGRAME_COUNTER_STAGE,
    output logic                                    STALL_INSTRUCTION_CACHE,
    output logic                                    STALL_INSTRUCTION_FETCH_STAGE,
    output logic                                    STALL_DECODING_STAGE,
    output logic                                    STALL_EXECUTION_STAGE,
    output logic                                    STALL_DATA_CACHE,
    output logic                                    STALL_DATA_MEMORY_STAGE,
    output logic                                    CLEAR_DECODING_STAGE,
    output logic                                    CLEAR_EXECUTION_STAGE,
    output logic                                    FLUSH_ACTIVE,
    output logic                                    HAZARD_TIMEOUT,
    output logic [CNT_WIDTH-1:0]                    STALL_CYCLE_COUNT,
    output logic [CNT_WIDTH-1:0]                    FLUSH_COUNT
);

    // BRANCH_PENALTY is at most 15, so a 4-bit bubble counter always suffices.
    localparam int FC_W   = 4;
    localparam int WAIT_W = (STALL_TIMEOUT < 2) ? 1 : $clog2(STALL_TIMEOUT + 1);
    localparam logic [FC_W-1:0]   PEN_M1   = FC_W'(BRANCH_PENALTY - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STALL_TIMEOUT);

    typedef enum logic {ST_RUN, ST_FLUSH} state_e;

    state_e              state_q, state_d;
    logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                timeout_q, timeout_d;

    logic                dmiss, imiss, load_use, take;
    logic [REG_ADD_WIDTH-1:0] rd_k;
    logic                stall_fe, stall_id, stall_be, clr_id, clr_ex;

    assign dmiss = !DATA_CACHE_READY;
    assign imiss = !INSTRUCTION_CACHE_READY;

    // Load-use: any DM stage holding a load whose nonzero rd feeds EX.
    always_comb begin
        load_use = 1'b0;
        rd_k     = '0;
        for (int k = 0; k < DM_STAGES; k++) begin
            rd_k = RD_ADDRESS_DM[k*REG_ADD_WIDTH +: REG_ADD_WIDTH];
            if ((DATA_CACHE_LOAD_DM[k*D_CACHE_LW_WIDTH +: D_CACHE_LW_WIDTH] != '0) &&
                (rd_k != '0) &&
                ((rd_k == RS1_ADDRESS_EXECUTION) || (rd_k == RS2_ADDRESS_EXECUTION)))
                load_use = 1'b1;
        end
    end

    // A branch only redirects when nothing older is holding the pipe.
    assign take = BRANCH_TAKEN_EXECUTION && !dmiss && !load_use;

    // Prioritised stall / clear decode.
    always_comb begin
        stall_fe = 1'b0;
        stall_id = 1'b0;
        stall_be = 1'b0;
        clr_id   = 1'b0;
        clr_ex   = 1'b0;
        if (dmiss) begin
            stall_fe = 1'b1;
            stall_id = 1'b1;
            stall_be = 1'b1;
        end else if (load_use) begin
            stall_fe = 1'b1;
            stall_id = 1'b1;
            clr_ex   = 1'b1;
        end else begin
            if (imiss) begin
                stall_fe = 1'b1;
                clr_id   = 1'b1;
            end
            if (take) begin
                clr_id = 1'b1;
                clr_ex = 1'b1;
            end
            if (state_q == ST_FLUSH)
                clr_id = 1'b1;
        end
    end

    // Flush FSM next state: a take (re)loads the bubble count, dmiss freezes it.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (!dmiss) begin
            if (take) begin
                flush_cnt_d = PEN_M1;
                state_d     = (BRANCH_PENALTY > 1) ? ST_FLUSH : ST_RUN;
            end else if (state_q == ST_FLUSH) begin
                if (flush_cnt_q <= FC_W'(1)) begin
                    flush_cnt_d = '0;
                    state_d     = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
        end
    end

    // Cache-wait counter saturates at the timeout; the timeout flag is sticky.
    always_comb begin
        wait_d = '0;
        if (dmiss || imiss)
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
        timeout_d = timeout_q || (wait_d == WAIT_MAX);
    end

    // Control state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            wait_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_q      <= wait_d;
            timeout_q   <= timeout_d;
        end
    end

    assign STALL_PROGRAME_COUNTER_STAGE  = stall_fe;
    assign STALL_INSTRUCTION_CACHE       = stall_fe;
    assign STALL_INSTRUCTION_FETCH_STAGE = stall_fe;
    assign STALL_DECODING_STAGE          = stall_id;
    assign STALL_EXECUTION_STAGE         = stall_be;
    assign STALL_DATA_CACHE              = stall_be;
    assign STALL_DATA_MEMORY_STAGE       = stall_be;
    assign CLEAR_DECODING_STAGE          = clr_id;
    assign CLEAR_EXECUTION_STAGE         = clr_ex;
    assign FLUSH_ACTIVE                  = (state_q == ST_FLUSH);
    assign HAZARD_TIMEOUT                = timeout_q;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

    // Saturating performance counters.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_fe && !(&stall_count_q))
            stall_count_d = stall_count_q + 1'b1;
        if (take && !(&flush_count_q))
            flush_count_d = flush_count_q + 1'b1;
    end

    // Performance counter registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign STALL_CYCLE_COUNT = stall_count_q;
    assign FLUSH_COUNT       = flush_count_q;
`else
    assign STALL_CYCLE_COUNT = '0;
    assign FLUSH_COUNT       = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (BRANCH_PENALTY=3,
// STALL_TIMEOUT=8). Expected output vectors are queued as each step is
// driven and popped for comparison on the falling edge.
module tb_pipeline_hazard_controller;

    localparam int RW = 5;
    localparam int LW = 3;
    localparam int NS = 3;
    localparam int CW = 16;

    logic CLK = 1'b0;
    logic RST_N;
    logic ic_rdy, dc_rdy, br;
    logic [RW-1:0] rs1, rs2;
    logic [NS*LW-1:0] ld;
    logic [NS*RW-1:0] rd;
    logic s_pc, s_ic, s_if, s_id, s_ex, s_dc, s_dm, c_id, c_ex, f_act, h_to;
    logic [CW-1:0] sc_cnt, fl_cnt;

    pipeline_hazard_controller #(
        .REG_ADD_WIDTH(RW), .D_CACHE_LW_WIDTH(LW), .DM_STAGES(NS),
        .BRANCH_PENALTY(3), .STALL_TIMEOUT(8), .CNT_WIDTH(CW)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .INSTRUCTION_CACHE_READY(ic_rdy), .DATA_CACHE_READY(dc_rdy),
        .BRANCH_TAKEN_EXECUTION(br),
        .RS1_ADDRESS_EXECUTION(rs1), .RS2_ADDRESS_EXECUTION(rs2),
        .DATA_CACHE_LOAD_DM(ld), .RD_ADDRESS_DM(rd),
        .STALL_PROGRAME_COUNTER_STAGE(s_pc), .STALL_INSTRUCTION_CACHE(s_ic),
        .STALL_INSTRUCTION_FETCH_STAGE(s_if), .STALL_DECODING_STAGE(s_id),
        .STALL_EXECUTION_STAGE(s_ex), .STALL_DATA_CACHE(s_dc),
        .STALL_DATA_MEMORY_STAGE(s_dm),
        .CLEAR_DECODING_STAGE(c_id), .CLEAR_EXECUTION_STAGE(c_ex),
        .FLUSH_ACTIVE(f_act), .HAZARD_TIMEOUT(h_to),
        .STALL_CYCLE_COUNT(sc_cnt), .FLUSH_COUNT(fl_cnt)
    );

    always #5 CLK = ~CLK;

    // obs layout: [10:4] seven stalls (PC first), [3] CLR_ID, [2] CLR_EX, [1] FLUSH_ACTIVE, [0] TIMEOUT
    logic [10:0] obs;
    assign obs = {s_pc, s_ic, s_if, s_id, s_ex, s_dc, s_dm, c_id, c_ex, f_act, h_to};

    localparam logic [6:0] ST_NO  = 7'b0000000;
    localparam logic [6:0] ST_ALL = 7'b1111111;
    localparam logic [6:0] ST_LU  = 7'b1111000;
    localparam logic [6:0] ST_IM  = 7'b1110000;

    typedef struct {
        string       tag;
        logic [10:0] v;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int n_clr_id = 0;
    logic [CW-1:0] exp_sc = '0;
    logic [CW-1:0] exp_fc = '0;

    function automatic logic [10:0] ev(logic [6:0] st, logic ci, logic ce, logic fa, logic to);
        return {st, ci, ce, fa, to};
    endfunction

    task automatic drive(input logic ic, input logic dc, input logic b,
                         input logic [RW-1:0] a1, input logic [RW-1:0] a2,
                         input logic [NS*LW-1:0] l, input logic [NS*RW-1:0] r);
        ic_rdy = ic; dc_rdy = dc; br = b; rs1 = a1; rs2 = a2; ld = l; rd = r;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic chk(input string tag, input logic [10:0] e);
        exp_t it;
        it.tag = tag;
        it.v   = e;
        exp_q.push_back(it);
        @(negedge CLK);
        it = exp_q.pop_front();
        checks++;
        assert (obs === it.v) else begin
            errors++;
            $error("FAIL %s: outputs got %b expected %b", it.tag, obs, it.v);
        end
        checks++;
        assert (sc_cnt === exp_sc) else begin
            errors++;
            $error("FAIL %s_stall_cnt: got %0d expected %0d", it.tag, sc_cnt, exp_sc);
        end
        checks++;
        assert (fl_cnt === exp_fc) else begin
            errors++;
            $error("FAIL %s_flush_cnt: got %0d expected %0d", it.tag, fl_cnt, exp_fc);
        end
        n_clr_id += int'(c_id);
`ifdef HAZARD_PERF_COUNTERS_EN
        if (RST_N) begin
            if (it.v[10]) exp_sc++;
            if (it.v[2] && !it.v[10]) exp_fc++;
        end
`endif
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N  = 1'b0;
        exp_sc = '0;
        exp_fc = '0;
    endtask

    initial begin
        idle();
        do_reset();
        chk("reset", ev(ST_NO, 0, 0, 0, 0));
        RST_N = 1'b1;
        chk("idle", ev(ST_NO, 0, 0, 0, 0));

        // load-use: DM2 load, rd=5 hits RS1
        drive(1, 1, 0, 5'd5, 5'd9, 9'b000_010_000, {5'd0, 5'd5, 5'd0});
        chk("lu_dm2_rs1", ev(ST_LU, 0, 1, 0, 0));
        // rd=x0 never matches
        drive(1, 1, 0, 5'd0, 5'd9, 9'b000_010_000, {5'd0, 5'd0, 5'd0});
        chk("lu_x0", ev(ST_NO, 0, 0, 0, 0));
        // DM3 load hits RS2
        drive(1, 1, 0, 5'd1, 5'd7, 9'b001_000_000, {5'd7, 5'd0, 5'd0});
        chk("lu_dm3_rs2", ev(ST_LU, 0, 1, 0, 0));
        // matching rd but no load
        drive(1, 1, 0, 5'd7, 5'd7, 9'b000_000_000, {5'd7, 5'd7, 5'd7});
        chk("lu_noload", ev(ST_NO, 0, 0, 0, 0));

        // dmiss for 4 cycles over a DM1 load hazard, then load-use takes over
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 5'd3, 5'd0, 9'b000_000_100, {5'd0, 5'd0, 5'd3});
            chk("dmiss_over_lu", ev(ST_ALL, 0, 0, 0, 0));
        end
        drive(1, 1, 0, 5'd3, 5'd0, 9'b000_000_100, {5'd0, 5'd0, 5'd3});
        chk("lu_after_dmiss", ev(ST_LU, 0, 1, 0, 0));
        idle();
        chk("idle2", ev(ST_NO, 0, 0, 0, 0));

        // single imiss
        drive(0, 1, 0, '0, '0, '0, '0);
        chk("imiss", ev(ST_IM, 1, 0, 0, 0));

        // taken branch, penalty 3
        drive(1, 1, 1, '0, '0, '0, '0);
        chk("br_c0", ev(ST_NO, 1, 1, 0, 0));
        idle();
        chk("br_c1", ev(ST_NO, 1, 0, 1, 0));
        chk("br_c2", ev(ST_NO, 1, 0, 1, 0));
        chk("br_c3", ev(ST_NO, 0, 0, 0, 0));

        // dmiss mid-flush freezes the bubble count
        n_clr_id = 0;
        drive(1, 1, 1, '0, '0, '0, '0);
        chk("brd_c0", ev(ST_NO, 1, 1, 0, 0));
        idle();
        chk("brd_c1", ev(ST_NO, 1, 0, 1, 0));
        drive(1, 0, 0, '0, '0, '0, '0);
        chk("brd_miss0", ev(ST_ALL, 0, 0, 1, 0));
        chk("brd_miss1", ev(ST_ALL, 0, 0, 1, 0));
        idle();
        chk("brd_c2", ev(ST_NO, 1, 0, 1, 0));
        chk("brd_done", ev(ST_NO, 0, 0, 0, 0));
        checks++;
        assert (n_clr_id === 3) else begin
            errors++;
            $error("FAIL brd_clr_id_total: got %0d expected 3", n_clr_id);
        end

        // second take inside FLUSH reloads the count
        drive(1, 1, 1, '0, '0, '0, '0);
        chk("brr_c0", ev(ST_NO, 1, 1, 0, 0));
        chk("brr_c1", ev(ST_NO, 1, 1, 1, 0));
        idle();
        chk("brr_c2", ev(ST_NO, 1, 0, 1, 0));
        chk("brr_c3", ev(ST_NO, 1, 0, 1, 0));
        chk("brr_done", ev(ST_NO, 0, 0, 0, 0));

        // imiss held: timeout after 8 cycles, sticky until reset
        drive(0, 1, 0, '0, '0, '0, '0);
        for (int i = 0; i < 10; i++)
            chk("imiss_to", ev(ST_IM, 1, 0, 0, (i >= 8)));
        idle();
        chk("to_sticky0", ev(ST_NO, 0, 0, 0, 1));
        chk("to_sticky1", ev(ST_NO, 0, 0, 0, 1));
        do_reset();
        chk("to_reset", ev(ST_NO, 0, 0, 0, 0));
        RST_N = 1'b1;
        chk("to_cleared", ev(ST_NO, 0, 0, 0, 0));

        // reset mid-flush abandons the flush
        drive(1, 1, 1, '0, '0, '0, '0);
        chk("brx_c0", ev(ST_NO, 1, 1, 0, 0));
        idle();
        chk("brx_c1", ev(ST_NO, 1, 0, 1, 0));
        do_reset();
        #1;
        checks++;
        assert (f_act === 1'b0) else begin
            errors++;
            $error("FAIL brx_async: FLUSH_ACTIVE got %b expected 0", f_act);
        end
        chk("brx_rst", ev(ST_NO, 0, 0, 0, 0));
        RST_N = 1'b1;
        chk("brx_run", ev(ST_NO, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
